// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
// Latches decoded fields, resolves EX-stage operand forwarding, detects
// load-use / RAW hazards and sequences stall, flush and bubble insertion.
// Optional macro ID_EX_FWD_EN: when defined, operands are forwarded from
// EX/MEM and MEM/WB; when undefined, no forwarding and hazard also covers
// every RAW dependency on EX, EX/MEM and MEM/WB destinations.
module id_ex_stage #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned OP_W   = 4,
  parameter int unsigned SHAM_W = 5,
  parameter int unsigned REG_W  = 5
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              id_valid,
  input  logic [WORD_W-1:0] id_rdat1,
  input  logic [WORD_W-1:0] id_rdat2,
  input  logic [WORD_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [OP_W-1:0]   id_opcode,
  input  logic [SHAM_W-1:0] id_shamt,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_wsel,
  input  logic              id_regwen,
  input  logic              id_memread,
  input  logic              stall,
  input  logic              flush,
  input  logic [REG_W-1:0]  exmem_wsel,
  input  logic              exmem_regwen,
  input  logic [WORD_W-1:0] exmem_res,
  input  logic [REG_W-1:0]  memwb_wsel,
  input  logic              memwb_regwen,
  input  logic [WORD_W-1:0] memwb_wdat,
  output logic              ex_valid,
  output logic [WORD_W-1:0] alu_op1,
  output logic [WORD_W-1:0] alu_op2,
  output logic [OP_W-1:0]   alu_opcode,
  output logic [SHAM_W-1:0] alu_shamt,
  output logic [REG_W-1:0]  ex_wsel,
  output logic              ex_regwen,
  output logic              ex_memread,
  output logic [WORD_W-1:0] ex_store_dat,
  output logic              hazard
);

  logic              r_valid;
  logic              r_flush_pend;
  logic [WORD_W-1:0] r_rdat1;
  logic [WORD_W-1:0] r_rdat2;
  logic [WORD_W-1:0] r_imm;
  logic              r_alusrc;
  logic [OP_W-1:0]   r_opcode;
  logic [SHAM_W-1:0] r_shamt;
  logic [REG_W-1:0]  r_rs;
  logic [REG_W-1:0]  r_rt;
  logic [REG_W-1:0]  r_wsel;
  logic              r_regwen;
  logic              r_memread;

  logic              w_load_use;
  logic              w_hazard;
  logic              w_bubble;
  logic [WORD_W-1:0] w_fwd_rs;
  logic [WORD_W-1:0] w_fwd_rt;

  assign ex_valid   = r_valid;
  assign ex_regwen  = r_regwen & r_valid;
  assign ex_memread = r_memread & r_valid;
  assign ex_wsel    = r_wsel;
  assign alu_opcode = r_opcode;
  assign alu_shamt  = r_shamt;

  // Load-use: the instruction in EX is a load whose result decode needs now.
  assign w_load_use = id_valid & ex_valid & ex_memread & (r_wsel != '0) &
                      ((r_wsel == id_rs) | (r_wsel == id_rt));

`ifdef ID_EX_FWD_EN
  // Forward newest producer first; register 0 is never forwarded.
  always_comb begin
    w_fwd_rs = r_rdat1;
    w_fwd_rt = r_rdat2;
    if (exmem_regwen && (exmem_wsel != '0) && (exmem_wsel == r_rs))
      w_fwd_rs = exmem_res;
    else if (memwb_regwen && (memwb_wsel != '0) && (memwb_wsel == r_rs))
      w_fwd_rs = memwb_wdat;
    if (exmem_regwen && (exmem_wsel != '0) && (exmem_wsel == r_rt))
      w_fwd_rt = exmem_res;
    else if (memwb_regwen && (memwb_wsel != '0) && (memwb_wsel == r_rt))
      w_fwd_rt = memwb_wdat;
  end

  assign w_hazard = w_load_use;
`else
  logic w_raw_ex;
  logic w_raw_exmem;
  logic w_raw_memwb;
  logic w_unused;

  // Without forwarding every in-flight producer of a decode source stalls.
  assign w_raw_ex    = ex_regwen & (r_wsel != '0) &
                       ((r_wsel == id_rs) | (r_wsel == id_rt));
  assign w_raw_exmem = exmem_regwen & (exmem_wsel != '0) &
                       ((exmem_wsel == id_rs) | (exmem_wsel == id_rt));
  assign w_raw_memwb = memwb_regwen & (memwb_wsel != '0) &
                       ((memwb_wsel == id_rs) | (memwb_wsel == id_rt));

  assign w_fwd_rs = r_rdat1;
  assign w_fwd_rt = r_rdat2;
  assign w_hazard = w_load_use |
                    (id_valid & (w_raw_ex | w_raw_exmem | w_raw_memwb));
  assign w_unused = ^{exmem_res, memwb_wdat, r_rs, r_rt};
`endif

  // Hazard is held low while the stage is in reset.
  assign hazard = w_hazard & nRST;

  assign alu_op1      = w_fwd_rs;
  assign alu_op2      = r_alusrc ? r_imm : w_fwd_rt;
  assign ex_store_dat = w_fwd_rt;

  assign w_bubble = flush | r_flush_pend | w_hazard;

  // EX slot register: stall holds, flush/hazard bubbles, otherwise capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_rdat1      <= '0;
      r_rdat2      <= '0;
      r_imm        <= '0;
      r_alusrc     <= 1'b0;
      r_opcode     <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wsel       <= '0;
      r_regwen     <= 1'b0;
      r_memread    <= 1'b0;
    end else if (stall) begin
      if (flush) r_flush_pend <= 1'b1;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_flush_pend <= 1'b0;
      r_rdat1      <= '0;
      r_rdat2      <= '0;
      r_imm        <= '0;
      r_alusrc     <= 1'b0;
      r_opcode     <= '0;
      r_shamt      <= '0;
      r_rs         <= '0;
      r_rt         <= '0;
      r_wsel       <= '0;
      r_regwen     <= 1'b0;
      r_memread    <= 1'b0;
    end else begin
      r_valid      <= id_valid;
      r_rdat1      <= id_rdat1;
      r_rdat2      <= id_rdat2;
      r_imm        <= id_imm;
      r_alusrc     <= id_alusrc;
      r_opcode     <= id_opcode;
      r_shamt      <= id_shamt;
      r_rs         <= id_rs;
      r_rt         <= id_rt;
      r_wsel       <= id_wsel;
      r_regwen     <= id_regwen & id_valid;
      r_memread    <= id_memread & id_valid;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, capture, alusrc, load-use bubble,
// stall/flush sequencing, and build-specific forwarding or RAW hazard.
module tb_id_ex_stage;

  logic        CLK;
  logic        nRST;
  logic        id_valid;
  logic [31:0] id_rdat1;
  logic [31:0] id_rdat2;
  logic [31:0] id_imm;
  logic        id_alusrc;
  logic [3:0]  id_opcode;
  logic [4:0]  id_shamt;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_wsel;
  logic        id_regwen;
  logic        id_memread;
  logic        stall;
  logic        flush;
  logic [4:0]  exmem_wsel;
  logic        exmem_regwen;
  logic [31:0] exmem_res;
  logic [4:0]  memwb_wsel;
  logic        memwb_regwen;
  logic [31:0] memwb_wdat;
  logic        ex_valid;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [3:0]  alu_opcode;
  logic [4:0]  alu_shamt;
  logic [4:0]  ex_wsel;
  logic        ex_regwen;
  logic        ex_memread;
  logic [31:0] ex_store_dat;
  logic        hazard;

  int n_cmp = 0;
  int n_err = 0;

  id_ex_stage dut (
    .CLK(CLK), .nRST(nRST),
    .id_valid(id_valid), .id_rdat1(id_rdat1), .id_rdat2(id_rdat2),
    .id_imm(id_imm), .id_alusrc(id_alusrc), .id_opcode(id_opcode),
    .id_shamt(id_shamt), .id_rs(id_rs), .id_rt(id_rt), .id_wsel(id_wsel),
    .id_regwen(id_regwen), .id_memread(id_memread),
    .stall(stall), .flush(flush),
    .exmem_wsel(exmem_wsel), .exmem_regwen(exmem_regwen), .exmem_res(exmem_res),
    .memwb_wsel(memwb_wsel), .memwb_regwen(memwb_regwen), .memwb_wdat(memwb_wdat),
    .ex_valid(ex_valid), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .ex_wsel(ex_wsel),
    .ex_regwen(ex_regwen), .ex_memread(ex_memread),
    .ex_store_dat(ex_store_dat), .hazard(hazard)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then driven away from it.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // Reset with a live decode instruction and a matching EX/MEM producer.
    nRST = 1'b0; id_valid = 1'b1; id_rdat1 = 32'h123; id_rdat2 = 32'h456;
    id_imm = 32'h789; id_alusrc = 1'b0; id_opcode = 4'h5; id_shamt = 5'd9;
    id_rs = 5'd2; id_rt = 5'd3; id_wsel = 5'd6; id_regwen = 1'b1;
    id_memread = 1'b1; stall = 1'b0; flush = 1'b0;
    exmem_wsel = 5'd2; exmem_regwen = 1'b1; exmem_res = 32'hDEAD;
    memwb_wsel = 5'd3; memwb_regwen = 1'b1; memwb_wdat = 32'hBEEF;
    tick(); tick(); #1;
    chk("rst_valid",  32'(ex_valid), 32'd0);
    chk("rst_op1",    alu_op1, 32'd0);
    chk("rst_op2",    alu_op2, 32'd0);
    chk("rst_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_shamt",  32'(alu_shamt), 32'd0);
    chk("rst_wsel",   32'(ex_wsel), 32'd0);
    chk("rst_regwen", 32'(ex_regwen), 32'd0);
    chk("rst_memrd",  32'(ex_memread), 32'd0);
    chk("rst_store",  ex_store_dat, 32'd0);
    chk("rst_hazard", 32'(hazard), 32'd0);

    // First instruction after reset: plain register operands.
    id_rdat1 = 32'd5; id_rdat2 = 32'd7; id_alusrc = 1'b0; id_opcode = 4'h2;
    id_shamt = 5'd3; id_rs = 5'd1; id_rt = 5'd2; id_wsel = 5'd3;
    id_regwen = 1'b1; id_memread = 1'b0;
    exmem_regwen = 1'b0; memwb_regwen = 1'b0;
    nRST = 1'b1;
    tick();
    chk("cap_valid",  32'(ex_valid), 32'd1);
    chk("cap_op1",    alu_op1, 32'd5);
    chk("cap_op2",    alu_op2, 32'd7);
    chk("cap_opcode", 32'(alu_opcode), 32'h2);
    chk("cap_shamt",  32'(alu_shamt), 32'd3);
    chk("cap_wsel",   32'(ex_wsel), 32'd3);
    chk("cap_regwen", 32'(ex_regwen), 32'd1);
    chk("cap_store",  ex_store_dat, 32'd7);
    chk("cap_hazard", 32'(hazard), 32'd0);

    // Immediate operand: op2 takes imm, store data still takes rt.
    id_alusrc = 1'b1; id_imm = 32'hFFFF_FFF0; id_rdat2 = 32'd9;
    id_rdat1 = 32'h11; id_rs = 5'd5; id_rt = 5'd6; id_wsel = 5'd7;
    tick();
    chk("imm_op1",   alu_op1, 32'h11);
    chk("imm_op2",   alu_op2, 32'hFFFF_FFF0);
    chk("imm_store", ex_store_dat, 32'd9);

    // Load into r4 enters EX.
    id_memread = 1'b1; id_regwen = 1'b1; id_wsel = 5'd4; id_rs = 5'd8;
    id_rt = 5'd9; id_rdat1 = 32'h40; id_imm = 32'h10; id_alusrc = 1'b1;
    tick();
    chk("ld_memrd", 32'(ex_memread), 32'd1);
    chk("ld_wsel",  32'(ex_wsel), 32'd4);
    // Consumer of r4 in decode: load-use hazard, then bubble, then capture.
    id_rs = 5'd4; id_rt = 5'd10; id_rdat1 = 32'h50; id_rdat2 = 32'h60;
    id_alusrc = 1'b0; id_memread = 1'b0; id_wsel = 5'd11; id_opcode = 4'h1;
    #1;
    chk("lu_hazard", 32'(hazard), 32'd1);
    tick();
    chk("lu_bub_valid",  32'(ex_valid), 32'd0);
    chk("lu_bub_regwen", 32'(ex_regwen), 32'd0);
    chk("lu_bub_memrd",  32'(ex_memread), 32'd0);
    chk("lu_bub_op1",    alu_op1, 32'd0);
    chk("lu_hazard_clr", 32'(hazard), 32'd0);
    tick();
    chk("lu_cap_valid", 32'(ex_valid), 32'd1);
    chk("lu_cap_op1",   alu_op1, 32'h50);
    chk("lu_cap_op2",   alu_op2, 32'h60);
    chk("lu_cap_wsel",  32'(ex_wsel), 32'd11);

    // Stall with flush, then plain stall twice: EX holds; release bubbles.
    id_rs = 5'd12; id_rt = 5'd13; id_wsel = 5'd14; id_rdat1 = 32'h77;
    id_rdat2 = 32'h88;
    stall = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("st0_valid", 32'(ex_valid), 32'd1);
    chk("st0_op1",   alu_op1, 32'h50);
    tick();
    chk("st1_op1",  alu_op1, 32'h50);
    chk("st1_wsel", 32'(ex_wsel), 32'd11);
    tick();
    chk("st2_valid", 32'(ex_valid), 32'd1);
    chk("st2_op1",   alu_op1, 32'h50);
    stall = 1'b0;
    tick();
    chk("fp_bub_valid", 32'(ex_valid), 32'd0);
    chk("fp_bub_wsel",  32'(ex_wsel), 32'd0);
    tick();
    chk("fp_cap_valid", 32'(ex_valid), 32'd1);
    chk("fp_cap_op1",   alu_op1, 32'h77);

`ifdef ID_EX_FWD_EN
    // Forwarding priority: EX/MEM over MEM/WB over latched data.
    id_rs = 5'd3; id_rt = 5'd0; id_rdat1 = 32'd1; id_rdat2 = 32'd2;
    id_regwen = 1'b0; id_wsel = 5'd0;
    tick();
    exmem_wsel = 5'd3; exmem_regwen = 1'b1; exmem_res = 32'hAA;
    memwb_wsel = 5'd3; memwb_regwen = 1'b1; memwb_wdat = 32'hBB;
    #1;
    chk("fwd_exmem", alu_op1, 32'hAA);
    exmem_regwen = 1'b0;
    #1;
    chk("fwd_memwb", alu_op1, 32'hBB);
    id_rs = 5'd0; id_rdat1 = 32'h33;
    tick();
    exmem_wsel = 5'd0; exmem_regwen = 1'b1; memwb_wsel = 5'd0;
    #1;
    chk("fwd_r0", alu_op1, 32'h33);
    chk("fwd_r0_store", ex_store_dat, 32'd2);
`else
    // RAW on an EX/MEM producer without forwarding: hazard and bubble.
    exmem_wsel = 5'd2; exmem_regwen = 1'b1; exmem_res = 32'hAA;
    id_rs = 5'd2; id_rt = 5'd0; id_wsel = 5'd15; id_valid = 1'b1;
    #1;
    chk("raw_exmem_hazard", 32'(hazard), 32'd1);
    tick();
    chk("raw_bub_valid",  32'(ex_valid), 32'd0);
    chk("raw_bub_regwen", 32'(ex_regwen), 32'd0);
    exmem_regwen = 1'b0;
    #1;
    chk("raw_clear", 32'(hazard), 32'd0);
    memwb_wsel = 5'd2; memwb_regwen = 1'b1;
    #1;
    chk("raw_memwb_hazard", 32'(hazard), 32'd1);
    memwb_wsel = 5'd0; id_rs = 5'd0;
    #1;
    chk("raw_r0_no_hazard", 32'(hazard), 32'd0);
`endif

    // Direct flush squashes the next capture.
    memwb_regwen = 1'b0; exmem_regwen = 1'b0;
    id_rs = 5'd1; id_rt = 5'd1; id_wsel = 5'd9; id_rdat1 = 32'h99;
    flush = 1'b1;
    tick();
    chk("flush_valid", 32'(ex_valid), 32'd0);
    flush = 1'b0;
    tick();
    chk("post_flush_op1", alu_op1, 32'h99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
